// File: rtl/norm_shift_ctrl_pkg.sv
// norm_shift_ctrl_pkg: shared FPU add/subtract definitions for the normalisation controller.
package norm_shift_ctrl_pkg;
    localparam int CHUNK = 4;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/norm_shift_ctrl_lz_chunk4.sv
// lz_chunk4: leading-zero count and nonzero flag of a 4-bit chunk.
module lz_chunk4 (
    input  logic [3:0] i_d,
    output logic [1:0] o_lz,
    output logic       o_nz
);
    assign o_nz = |i_d;
    assign o_lz = i_d[3] ? 2'd0 : i_d[2] ? 2'd1 : i_d[1] ? 2'd2 : 2'd3;
endmodule

// File: rtl/norm_shift_ctrl.sv
// norm_shift_ctrl: finds the normalisation shift of an adder result by scanning
// 4-bit chunks from the MSB, one chunk per cycle; carry-out forces a 1-bit right shift.
module norm_shift_ctrl
    import norm_shift_ctrl_pkg::*;
#(
    parameter int SWR = 26,
    parameter int EWR = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [SWR-1:0] Data_i,
    input  logic           Add_Overflow_i,
    output logic           ready_o,
    output logic           done_o,
    output logic [EWR-1:0] Shift_Value_o,
    output logic           Left_Right_o,
    output logic           Bit_Shift_o,
    output logic           zero_o
);
    localparam int NCH = (SWR + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t         r_state;
    logic [SWR-1:0] r_data;
    logic           r_ovf;
    logic [KW-1:0]  r_k;
    logic [EWR-1:0] r_sv;
    logic           r_lr;
    logic           r_bs;
    logic           r_zero;

    logic [PW-1:0]    w_pad;
    logic [CHUNK-1:0] w_chunk;
    logic [1:0]       w_lz;
    logic             w_nz;
    logic [EWR-1:0]   w_sv;

    // left-align the data so the last chunk is zero-padded below bit 0
    assign w_pad   = PW'(r_data) << (PW - SWR);
    assign w_chunk = CHUNK'(w_pad >> (PW - CHUNK - CHUNK * int'(r_k)));
    assign w_sv    = EWR'(CHUNK * int'(r_k)) + EWR'(w_lz);

    lz_chunk4 u_lz (
        .i_d  (w_chunk),
        .o_lz (w_lz),
        .o_nz (w_nz)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_k     <= '0;
            r_sv    <= '0;
            r_lr    <= 1'b0;
            r_bs    <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_data <= Data_i;
                    r_ovf  <= Add_Overflow_i;
                    r_k    <= '0;
                    if (Add_Overflow_i) begin
                        r_state <= DONE;
                        r_sv    <= EWR'(1);
                        r_lr    <= 1'b0;
                        r_bs    <= 1'b1;
                        r_zero  <= 1'b0;
                    end else begin
                        r_state <= SCAN;
                    end
                end
                SCAN: if (w_nz) begin
                    r_state <= DONE;
                    r_sv    <= w_sv;
                    r_lr    <= 1'b1;
                    r_bs    <= 1'b0;
                    r_zero  <= 1'b0;
                end else if (int'(r_k) == NCH - 1) begin
                    r_state <= DONE;
                    r_sv    <= '0;
                    r_lr    <= 1'b1;
                    r_bs    <= 1'b0;
                    r_zero  <= !r_ovf;
                end else begin
                    r_k <= r_k + 1'b1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o       = (r_state == IDLE);
    assign done_o        = (r_state == DONE);
    assign Shift_Value_o = r_sv;
    assign Left_Right_o  = r_lr;
    assign Bit_Shift_o   = r_bs;
    assign zero_o        = r_zero;
endmodule

// File: doc/norm_shift_ctrl.md
NORM_SHIFT_CTRL -- requirements
Module: norm_shift_ctrl

Interface
REQ-001 The block SHALL have parameter SWR, default 26, meaning significand width including the implicit, guard and round bits.
REQ-002 The block SHALL have parameter EWR, default 5, meaning shift-amount width; legal only when 2**EWR > SWR-1.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start_i  input  1  request to analyse Data_i; sampled only in IDLE.
REQ-006 The block SHALL have port Data_i  input  SWR  raw adder result significand, sampled with start_i.
REQ-007 The block SHALL have port Add_Overflow_i  input  1  adder carry-out, sampled with start_i.
REQ-008 The block SHALL have port ready_o  output  1  high in IDLE only.
REQ-009 The block SHALL have port done_o  output  1  one-cycle pulse when results are valid.
REQ-010 The block SHALL have port Shift_Value_o  output  EWR  shift amount for the barrel shifter.
REQ-011 The block SHALL have port Left_Right_o  output  1  shift direction, 1 = left (normalize), 0 = right.
REQ-012 The block SHALL have port Bit_Shift_o  output  1  fill bit for vacated positions.
REQ-013 The block SHALL have port zero_o  output  1  Data_i was all zeros and no overflow.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, DONE.
REQ-015 In IDLE with start_i=1, Data_i and Add_Overflow_i SHALL be captured into internal registers and chunk index k cleared to 0.
REQ-016 From IDLE with start_i=1 and Add_Overflow_i=1 the next state SHALL be DONE, loading Shift_Value_o=1, Left_Right_o=0, Bit_Shift_o=1, zero_o=0.
REQ-017 From IDLE with start_i=1 and Add_Overflow_i=0 the next state SHALL be SCAN.
REQ-018 In SCAN, each cycle SHALL examine 4-bit chunk k, bits [SWR-1-4k : SWR-4-4k], with bits below index 0 treated as zero.
REQ-019 If chunk k is nonzero, the block SHALL load Shift_Value_o = 4k + leading zeros within the chunk, Left_Right_o=1, Bit_Shift_o=0, zero_o=0, and go to DONE.
REQ-020 If chunk k is zero and k < NCH-1, with NCH = ceil(SWR/4) (7 for SWR=26), k SHALL increment and the state SHALL remain SCAN.
REQ-021 If chunk k is zero and k = NCH-1, the block SHALL load Shift_Value_o=0, Left_Right_o=1, Bit_Shift_o=0, zero_o=1, and go to DONE.
REQ-022 In DONE, done_o SHALL be 1 for exactly one cycle and the next state SHALL be IDLE.
REQ-023 Result outputs SHALL hold their values until the next result load or reset.
REQ-024 Latency from the start_i accept edge t SHALL be:
  - overflow: done_o at t+1;
  - leading one in chunk k: done_o at t+2+k;
  - all-zero: done_o at t+1+NCH.
REQ-025 start_i SHALL be ignored in SCAN and DONE; a held start_i SHALL be re-accepted in IDLE.
REQ-026 Shift_Value_o SHALL never exceed SWR-1.
REQ-027 All outputs SHALL be driven from registers or the state register, with no combinational path from inputs.

Reset
REQ-028 While rst=0, state SHALL be IDLE, k=0, ready_o=1, done_o=0, Shift_Value_o=0, Left_Right_o=0, Bit_Shift_o=0, zero_o=0, and captured data SHALL be cleared.
REQ-029 Reset asserted during SCAN or DONE SHALL abort the operation immediately, with no done_o pulse afterwards.

Structure
REQ-030 State encoding and CHUNK=4 SHALL reside in the shared FPU add/subtract package.
REQ-031 A combinational sub-module lz_chunk4 (4-bit in, 2-bit leading-zero count, nonzero flag) SHALL be instantiated once.

Verification (SWR=26, EWR=5)
REQ-032 Data_i=26'h2000000, Add_Overflow_i=0 -> done_o at t+2, Shift_Value_o=0, Left_Right_o=1, zero_o=0.
REQ-033 Data_i=26'h0080000 -> done_o at t+3, Shift_Value_o=6, Left_Right_o=1, Bit_Shift_o=0.
REQ-034 Data_i=26'h0000001 -> done_o at t+8, Shift_Value_o=25; Data_i=0 -> done_o at t+8, zero_o=1, Shift_Value_o=0.
REQ-035 Add_Overflow_i=1 with any Data_i -> done_o at t+1, Shift_Value_o=1, Left_Right_o=0, Bit_Shift_o=1.
REQ-036 start_i pulsed during SCAN -> ignored, single done_o; rst=0 in SCAN cycle 2 -> all outputs at reset values, ready_o=1, no done_o.
